fwd_scoreboard: RTL
===================

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 SHALL have parameter NRP, default 2: number of operand read ports.
REQ-002 SHALL have parameter NSTG, default 3: number of forwarding source stages; index 0 is the youngest stage.
REQ-003 SHALL have parameter LD_LAT, default 2, range 1..7: cycles from load issue until the load data is forwardable.
REQ-004 SHALL have port CLK, in, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST, in, 1: synchronous active-high reset.
REQ-006 SHALL have port issue_v, in, 1: an instruction leaves decode this cycle.
REQ-007 SHALL have ports issue_wr and issue_ld, in, 1 each: the issuing instruction writes a register / is a load.
REQ-008 SHALL have port issue_dst, in, regbits_t: destination register of the issuing instruction.
REQ-009 SHALL have port flush, in, 1: squash all in-flight instructions.
REQ-010 SHALL have ports rs_addr[NRP], in, regbits_t: source register per read port.
REQ-011 SHALL have ports rs_rdat[NRP], in, word_t: register-file read data per read port.
REQ-012 SHALL have ports stg_wr[NSTG] and stg_rdy[NSTG], in, 1 each: stage writes a register / its data is final.
REQ-013 SHALL have ports stg_dst[NSTG], in, regbits_t, and stg_data[NSTG], in, word_t: per-stage destination and result.
REQ-014 SHALL have ports opnd[NRP], out, word_t: resolved operand per read port.
REQ-015 SHALL have ports fwd_hit[NRP], out, 1: the operand was taken from a stage, not the register file.
REQ-016 SHALL have port stall, out, 1: hold fetch/decode this cycle.
REQ-017 SHALL have port stall_cnt, out, 16: saturating count of stalled cycles.
REQ-018 SHALL have port stall_evt, out, 16: saturating count of RUN->STALL transitions.

Function
REQ-019 SHALL keep per-register pending counter pend[r], width 3, for r = 1..31; pend[0] SHALL be constant 0.
REQ-020 SHALL load pend[issue_dst] = LD_LAT when issue_v & issue_wr & issue_ld & !stall & issue_dst != 0.
REQ-021 SHALL otherwise decrement every nonzero pend[r] by 1 per cycle.
REQ-022 SHALL let a load issue to a register win over that register's decrement in the same cycle.
REQ-023 SHALL clear all pend[r] to 0 on flush; flush SHALL take priority over issue.
REQ-024 SHALL, per read port p, select the lowest stage index s with stg_wr[s] & stg_dst[s] == rs_addr[p] & rs_addr[p] != 0.
REQ-025 SHALL drive opnd[p] = stg_data[s] and fwd_hit[p] = 1 when that stage has stg_rdy[s] = 1.
REQ-026 SHALL drive opnd[p] = rs_rdat[p] and fwd_hit[p] = 0 when no stage matches.
REQ-027 SHALL drive opnd[p] = 0 and fwd_hit[p] = 0 when rs_addr[p] == 0, ignoring all stages.
REQ-028 SHALL define hazard[p] = rs_addr[p] != 0 & (pend[rs_addr[p]] != 0 | (the matched stage has stg_rdy = 0)).
REQ-029 SHALL assert stall combinationally when any hazard[p] is set and flush is 0; operand outputs are zero-latency.
REQ-030 SHALL implement an FSM with states RUN and STALL: RUN->STALL when stall = 1; STALL->RUN when stall = 0; any state -> RUN on flush.
REQ-031 SHALL increment stall_evt on each RUN->STALL transition, and stall_cnt on each cycle with stall = 1; both SHALL saturate at 16'hFFFF.
REQ-032 SHALL ignore issue_v while stall = 1, leaving pend unchanged except for decrement.

Reset
REQ-033 SHALL, on RST = 1 at a clock edge, set all pend = 0, FSM = RUN, stall_cnt = 0 and stall_evt = 0.
REQ-034 SHALL drive stall = 0 while RST = 1; RST SHALL override flush and issue in the same cycle.
REQ-035 SHALL clear all pending loads without replay when reset is applied mid-stall.

Structure
REQ-036 SHALL take word_t and regbits_t from cpu_types_pkg.
REQ-037 SHALL place the FSM state typedef fsb_state_t and the counter width constant in cpu_types_pkg.
REQ-038 SHALL instantiate one fwd_mux sub-module per read port, containing the priority stage match (REQ-024..027) and hazard[p].

Verification
REQ-039 SHALL cover this scenario: with stage 0 writing $5 = 32'h1111 (rdy = 1), stage 2 writing $5 = 32'h2222, and rs_addr[0] = 5 -> opnd[0] = 32'h1111, fwd_hit[0] = 1, stall = 0.
REQ-040 SHALL cover this scenario: load issue to $8 with LD_LAT = 2, then rs_addr[1] = 8 for the next cycles -> stall = 1 for exactly 2 cycles, stall_evt = 1, stall_cnt = 2.
REQ-041 SHALL cover this scenario: rs_addr[0] = 0 with a stage writing $0 = 32'hDEAD -> opnd[0] = 0, stall = 0.
REQ-042 SHALL cover this scenario: load to $3 issued, then flush in the next cycle with rs_addr[0] = 3 -> stall = 0 that cycle and after, FSM = RUN.
REQ-043 SHALL cover this scenario: 70000 consecutive stalled cycles -> stall_cnt saturates at 16'hFFFF.
REQ-044 SHALL cover this scenario: RST asserted during STALL with pend[9] = 2 -> the following cycle stall = 0, all counters 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types plus the forwarding-scoreboard state and counter widths.
package cpu_types_pkg;

    localparam int unsigned WordW   = 32;
    localparam int unsigned RegW    = 5;
    localparam int unsigned NumRegs = 32;
    localparam int unsigned PendW   = 3;
    localparam int unsigned CntW    = 16;

    typedef logic [WordW-1:0] word_t;
    typedef logic [RegW-1:0]  regbits_t;

    typedef enum logic [0:0] {
        StRun,
        StStall
    } fsb_state_t;

endpackage

// File: rtl/fwd_mux.sv
// Per-read-port operand select: youngest matching stage wins, $0 reads as zero.
module fwd_mux
    import cpu_types_pkg::*;
#(
    parameter int unsigned NSTG = 3
) (
    input  regbits_t rsAddr_i,
    input  word_t    rsRdat_i,
    input  logic     pendBusy_i,
    input  logic     stgWr_i   [NSTG],
    input  logic     stgRdy_i  [NSTG],
    input  regbits_t stgDst_i  [NSTG],
    input  word_t    stgData_i [NSTG],
    output word_t    opnd_o,
    output logic     fwdHit_o,
    output logic     hazard_o
);

    logic  matched;
    logic  matchRdy;
    word_t matchData;

    // Scan oldest to youngest so the lowest matching index is the one kept.
    always_comb begin
        matched   = 1'b0;
        matchRdy  = 1'b0;
        matchData = '0;
        for (int s = int'(NSTG) - 1; s >= 0; s--) begin
            if (stgWr_i[s] && (stgDst_i[s] == rsAddr_i)) begin
                matched   = 1'b1;
                matchRdy  = stgRdy_i[s];
                matchData = stgData_i[s];
            end
        end
    end

    always_comb begin
        opnd_o   = rsRdat_i;
        fwdHit_o = 1'b0;
        hazard_o = 1'b0;
        if (rsAddr_i == '0) begin
            opnd_o = '0;
        end else begin
            if (matched && matchRdy) begin
                opnd_o   = matchData;
                fwdHit_o = 1'b1;
            end
            hazard_o = pendBusy_i | (matched & ~matchRdy);
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Load-use scoreboard with operand forwarding, stall FSM and saturating stall statistics.
module fwd_scoreboard
    import cpu_types_pkg::*;
#(
    parameter int unsigned NRP    = 2,
    parameter int unsigned NSTG   = 3,
    parameter int unsigned LD_LAT = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            issue_v,
    input  logic            issue_wr,
    input  logic            issue_ld,
    input  regbits_t        issue_dst,
    input  logic            flush,
    input  regbits_t        rs_addr  [NRP],
    input  word_t           rs_rdat  [NRP],
    input  logic            stg_wr   [NSTG],
    input  logic            stg_rdy  [NSTG],
    input  regbits_t        stg_dst  [NSTG],
    input  word_t           stg_data [NSTG],
    output word_t           opnd     [NRP],
    output logic            fwd_hit  [NRP],
    output logic            stall,
    output logic [CntW-1:0] stall_cnt,
    output logic [CntW-1:0] stall_evt
);

    logic [PendW-1:0] pendQ [NumRegs];
    logic [PendW-1:0] pendD [NumRegs];
    fsb_state_t       stateQ, stateD;
    logic [CntW-1:0]  stallCntQ, stallCntD;
    logic [CntW-1:0]  stallEvtQ, stallEvtD;
    logic             hazard [NRP];
    logic             anyHazard;
    logic             loadIssue;

    for (genvar p = 0; p < int'(NRP); p++) begin : gPort
        fwd_mux #(
            .NSTG(NSTG)
        ) uMux (
            .rsAddr_i  (rs_addr[p]),
            .rsRdat_i  (rs_rdat[p]),
            .pendBusy_i(pendQ[rs_addr[p]] != '0),
            .stgWr_i   (stg_wr),
            .stgRdy_i  (stg_rdy),
            .stgDst_i  (stg_dst),
            .stgData_i (stg_data),
            .opnd_o    (opnd[p]),
            .fwdHit_o  (fwd_hit[p]),
            .hazard_o  (hazard[p])
        );
    end

    always_comb begin
        anyHazard = 1'b0;
        for (int p = 0; p < int'(NRP); p++) begin
            anyHazard = anyHazard | hazard[p];
        end
    end

    assign stall     = anyHazard & ~flush & ~RST;
    assign loadIssue = issue_v & issue_wr & issue_ld & ~stall & (issue_dst != '0);

    // A fresh load overrides the countdown of its own register; flush beats both.
    always_comb begin
        pendD[0] = '0;
        for (int r = 1; r < int'(NumRegs); r++) begin
            pendD[r] = (pendQ[r] != '0) ? pendQ[r] - PendW'(1) : '0;
        end
        if (loadIssue) begin
            pendD[issue_dst] = PendW'(LD_LAT);
        end
        if (flush) begin
            pendD = '{default: '0};
        end
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            StRun:   if (stall)  stateD = StStall;
            StStall: if (!stall) stateD = StRun;
            default: stateD = StRun;
        endcase
        if (flush) begin
            stateD = StRun;
        end
    end

    always_comb begin
        stallCntD = stallCntQ;
        stallEvtD = stallEvtQ;
        if (stall && (stallCntQ != '1)) begin
            stallCntD = stallCntQ + CntW'(1);
        end
        if (stall && (stateQ == StRun) && (stallEvtQ != '1)) begin
            stallEvtD = stallEvtQ + CntW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pendQ     <= '{default: '0};
            stateQ    <= StRun;
            stallCntQ <= '0;
            stallEvtQ <= '0;
        end else begin
            pendQ     <= pendD;
            stateQ    <= stateD;
            stallCntQ <= stallCntD;
            stallEvtQ <= stallEvtD;
        end
    end

    assign stall_cnt = stallCntQ;
    assign stall_evt = stallEvtQ;

endmodule
